// File: rtl/rca8_seq_add_ctrl.sv
// Serial multi-byte adder: one 8-bit ripple slice reused LSB-first, carry chained in a register.
// Latency WORDS cycles from accepted start to done; start is ignored while busy (no queueing).

module RCA_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [8:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[8];

endmodule

module rca8_seq_add_ctrl #(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [8*WORDS-1:0]   a,
  input  logic [8*WORDS-1:0]   b,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic [8*WORDS-1:0]   sum,
  output logic                 cout,
  output logic                 overflow
);

  localparam int W  = 8 * WORDS;
  localparam int IW = $clog2(WORDS);

  typedef enum logic {
    IDLE = 1'b0,
    ADD  = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            accept;
  logic            last;

  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    acc_q;
  logic [W-1:0]    acc_merged;
  logic            carry_q;
  logic [IW-1:0]   idx_q;

  logic [7:0]      a_byte;
  logic [7:0]      b_byte;
  logic [7:0]      s_byte;
  logic            s_cout;

  assign a_byte = a_q[{idx_q, 3'b000} +: 8];
  assign b_byte = b_q[{idx_q, 3'b000} +: 8];

  RCA_8bit u_slice (
    .a    (a_byte),
    .b    (b_byte),
    .cin  (carry_q),
    .sum  (s_byte),
    .cout (s_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ADD;
        end
      end
      ADD: begin
        if (idx_q == IW'(WORDS - 1)) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == ADD);

  // Final byte is merged here so the completion edge can publish the whole word at once.
  always_comb begin
    acc_merged = acc_q;
    acc_merged[{idx_q, 3'b000} +: 8] = s_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_q     <= a;
        b_q     <= b;
        carry_q <= cin;
        idx_q   <= '0;
        acc_q   <= '0;
      end else if (state == ADD) begin
        acc_q   <= acc_merged;
        carry_q <= s_cout;
        idx_q   <= idx_q + IW'(1);
        if (last) begin
          sum      <= acc_merged;
          cout     <= s_cout;
          // carry into bit 7 of the top slice is a7 ^ b7 ^ s7
          overflow <= a_byte[7] ^ b_byte[7] ^ s_byte[7] ^ s_cout;
          done     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rca8_seq_add_ctrl.sv
// Directed bench for rca8_seq_add_ctrl (WORDS=4) with hand-computed expected results.

module tb_rca8_seq_add_ctrl;

  localparam int WORDS = 4;
  localparam int W     = 8 * WORDS;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic          busy;
  logic          done;
  logic [W-1:0]  sum;
  logic          cout;
  logic          overflow;

  int errs   = 0;
  int checks = 0;

  rca8_seq_add_ctrl #(.WORDS(WORDS)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Start one addition, wait for done (bounded), check busy length and results.
  task automatic run_add(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic ci, input logic [W-1:0] es, input logic ec, input logic eo);
    int nbusy;
    @(negedge clk);
    start = 1'b1; a = av; b = bv; cin = ci;
    @(negedge clk);
    start = 1'b0;
    nbusy = 0;
    while (busy && nbusy < 20) begin
      nbusy++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, 64'(nbusy), 64'd4);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_sum"}, 64'(sum), 64'(es));
    chk({tag, "_cout"}, 64'(cout), 64'(ec));
    chk({tag, "_ovf"}, 64'(overflow), 64'(eo));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    chk({tag, "_sum_held"}, 64'(sum), 64'(es));
  endtask

  initial begin
    int ndone;
    int lat;
    logic [W-1:0] seen_sum;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    rst = 1'b0;

    run_add("small",  32'h0000_0007, 32'h0000_0003, 1'b0, 32'h0000_000A, 1'b0, 1'b0);
    run_add("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_add("posovf", 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b1);
    run_add("negovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);

    // start while busy is ignored; operand changes mid-operation have no effect
    @(negedge clk);
    start = 1'b1; a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    seen_sum = '0;
    for (int i = 1; i <= 12; i++) begin
      if (i == 1) begin
        start = 1'b1; a = 32'hAAAA_0000; b = 32'h0000_5555; cin = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) begin
        ndone++;
        seen_sum = sum;
      end
    end
    chk("busy_ign_ndone", 64'(ndone), 64'd1);
    chk("busy_ign_sum", 64'(seen_sum), 64'h2345_6789);
    chk("busy_ign_idle", 64'(busy), 64'd0);

    // reset during the second ADD cycle aborts with no done
    @(negedge clk);
    start = 1'b1; a = 32'h0101_0101; b = 32'h0202_0202; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_sum", 64'(sum), 64'd0);
    chk("abort_cout", 64'(cout), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'd0);

    // start accepted in the done cycle
    @(negedge clk);
    start = 1'b1; a = 32'h0000_00FF; b = 32'h0000_0001; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      lat++;
      @(negedge clk);
    end
    chk("b2b_first_done", 64'(done), 64'd1);
    chk("b2b_first_sum", 64'(sum), 64'h0000_0100);
    chk("b2b_first_busy", 64'(busy), 64'd0);
    start = 1'b1; a = 32'h0001_0000; b = 32'h0000_FFFF; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_accepted", 64'(busy), 64'd1);
    lat = 0;
    while (!done && lat < 20) begin
      lat++;
      @(negedge clk);
    end
    chk("b2b_latency", 64'(lat), 64'd4);
    chk("b2b_second_sum", 64'(sum), 64'h0001_FFFF);
    chk("b2b_second_cout", 64'(cout), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
